// File: rtl/fifo_rr_sched.sv
// Purpose: round-robin drain of NUM_CH FWFT FIFOs onto one registered, channel-tagged stream.
// Latency: head word valid in cycle t (scheduler idle) -> grant/pop in t+1 -> out_valid_o in t+2.
// Backpressure: out_ready_i low with out_valid_o high freezes output, pops and FSM.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en_i                arbitration enable (gates new grants only, never aborts a burst)
//   ch_data_i/_empty_i  head word and empty flag of each FIFO (channel k at [k*DATA_WIDTH +: DATA_WIDTH])
//   ch_rd_en_o          per-channel pop strobe, at most one bit high
//   out_data_o/_ch_o    registered output word and its source channel
//   out_valid_o/_ready_i output handshake
//   grant_o, busy_o     one-hot current grant; activity indicator
module fifo_rr_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_WIDTH   = 2,
  parameter int BURST_LEN  = 4,
  localparam int NUM_CH    = 2 ** CH_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]            ch_empty_i,
  output logic [NUM_CH-1:0]            ch_rd_en_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [CH_WIDTH-1:0]          out_ch_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NUM_CH-1:0]            grant_o,
  output logic                         busy_o
);

  // Burst counter only needs to reach BURST_LEN-1; keep at least one bit.
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  // Doubles as the granted channel while in S_GRANT.
  logic [CH_WIDTH-1:0]     r_last_grant;
  logic [CNT_W-1:0]        r_burst_cnt;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [CH_WIDTH-1:0]     r_out_ch;
  logic                    r_out_valid;

  logic                    w_can_load;
  logic                    w_g_empty;
  logic                    w_pop;
  logic                    w_start;
  logic [DATA_WIDTH-1:0]   w_g_data;
  logic                    w_sel_vld;
  logic [CH_WIDTH-1:0]     w_sel_ch;

  // Output register may load whenever it is empty or being drained this cycle.
  assign w_can_load = !r_out_valid || out_ready_i;
  assign w_g_empty  = ch_empty_i[r_last_grant];
  assign w_g_data   = ch_data_i[r_last_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_pop      = (r_state == S_GRANT) && !w_g_empty && w_can_load;
  assign w_start    = (r_state == S_IDLE) && en_i && w_sel_vld;

  // Round-robin search starting at last_grant+1. Iterating from the farthest
  // offset down lets the nearest non-empty channel overwrite the result.
  // Offset NUM_CH wraps to last_grant itself, so a lone channel is re-granted.
  always_comb begin
    logic [CH_WIDTH-1:0] v_idx;
    w_sel_vld = 1'b0;
    w_sel_ch  = '0;
    v_idx     = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      v_idx = r_last_grant + CH_WIDTH'(i);
      if (!ch_empty_i[v_idx]) begin
        w_sel_vld = 1'b1;
        w_sel_ch  = v_idx;
      end
    end
  end

  // Next-state logic. While the output is stalled nothing is evaluated,
  // so a channel going empty during a stall does not end the burst early.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_can_load) begin
          if (w_g_empty) begin
            w_state_nxt = S_IDLE;
          end else if (r_burst_cnt == LAST_CNT) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ch_rd_en_o = '0;
    if (w_pop) begin
      ch_rd_en_o[r_last_grant] = 1'b1;
    end
  end

  always_comb begin
    grant_o = '0;
    if (r_state == S_GRANT) begin
      grant_o[r_last_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= '1;
      r_burst_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_last_grant <= w_sel_ch;
        r_burst_cnt  <= '0;
      end else if (w_pop) begin
        r_burst_cnt  <= r_burst_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_out_data  <= w_g_data;
        r_out_ch    <= r_last_grant;
        r_out_valid <= 1'b1;
      end else if (w_can_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data_o  = r_out_data;
  assign out_ch_o    = r_out_ch;
  assign out_valid_o = r_out_valid;
  assign busy_o      = (r_state == S_GRANT) || r_out_valid;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Purpose: scoreboard bench for fifo_rr_sched with behavioural FWFT FIFOs per channel.
// Latency: expected words are queued at stimulus time; a monitor compares on each accepted output.
// Backpressure: out_ready_i driven by the directed sequences (stall and reset scenarios).
module tb_fifo_rr_sched;
  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int NCH = 4;
  localparam int BL  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en_i;
  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_empty_i;
  logic [NCH-1:0]    ch_rd_en_o;
  logic [DW-1:0]     out_data_o;
  logic [CW-1:0]     out_ch_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [NCH-1:0]    grant_o;
  logic              busy_o;

  fifo_rr_sched #(.DATA_WIDTH(DW), .CH_WIDTH(CW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .ch_data_i  (ch_data_i),
    .ch_empty_i (ch_empty_i),
    .ch_rd_en_o (ch_rd_en_o),
    .out_data_o (out_data_o),
    .out_ch_o   (out_ch_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int last_acc_cyc = 0;

  logic [7:0] fq[NCH][$];
  logic [9:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < NCH; k++) begin
      ch_empty_i[k] = (fq[k].size() == 0);
      ch_data_i[k*DW +: DW] = (fq[k].size() != 0) ? fq[k][0] : 8'h00;
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    fq[ch].push_back(d);
  endtask

  task automatic expect_w(input int ch, input logic [7:0] d);
    exp_q.push_back({2'(ch), d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  // Behavioural FIFOs: pop on the strobe seen at the edge, then present the new head.
  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (ch_rd_en_o[k]) begin
        chk("pop_on_empty", (fq[k].size() == 0), 0);
        if (fq[k].size() != 0) void'(fq[k].pop_front());
      end
    end
    #1;
    refresh();
  end

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", {out_ch_o, out_data_o});
      end else begin
        chk("out_word", {out_ch_o, out_data_o}, exp_q.pop_front());
        n_acc++;
        last_acc_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_cyc;
    int n0;
    bit found;
    ch_empty_i  = '1;
    ch_data_i   = '0;
    rst_n       = 1'b0;
    en_i        = 1'b1;
    out_ready_i = 1'b1;

    // Reset values
    #12;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_rd_en", ch_rd_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_ch", out_ch_o, 0);
    step();
    rst_n = 1'b1;

    // All empty, enabled: stays idle
    repeat (3) @(negedge clk);
    chk("idle_grant", grant_o, 0);
    chk("idle_rd_en", ch_rd_en_o, 0);
    chk("idle_valid", out_valid_o, 0);
    chk("idle_busy", busy_o, 0);

    // Single channel ch2 with 3 words
    step();
    push(2, 8'hA1); push(2, 8'hA2); push(2, 8'hA3);
    expect_w(2, 8'hA1); expect_w(2, 8'hA2); expect_w(2, 8'hA3);
    refresh();
    @(negedge clk);
    chk("ch2_grant_t", grant_o, 4'b0000);
    @(negedge clk);
    chk("ch2_grant_t1", grant_o, 4'b0100);
    chk("ch2_rd_en_t1", ch_rd_en_o, 4'b0100);
    chk("ch2_valid_t1", out_valid_o, 0);
    @(negedge clk);
    chk("ch2_valid_t2", out_valid_o, 1);
    chk("ch2_ch_t2", out_ch_o, 2);
    repeat (3) @(negedge clk);
    chk("ch2_grant_t5", grant_o, 0);
    chk("ch2_busy_t5", busy_o, 0);
    wait_drain(20);

    // Four channels, 10 words each, starting from a fresh pointer
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 10; k++) push(c, 8'(c * 16 + k));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NCH; c++)
        for (int k = r * 4; k < r * 4 + 4 && k < 10; k++) expect_w(c, 8'(c * 16 + k));
    n0 = n_acc;
    t_cyc = cyc;
    refresh();
    wait_drain(120);
    chk("all4_count", n_acc - n0, 40);
    // 8 full bursts (4 pops) + 4 dry bursts (2 pops + empty cycle) + 11 idle bubbles.
    chk("all4_last_cycle", last_acc_cyc - t_cyc, 55);

    // ch0 stream with 5-cycle stall
    step();
    for (int k = 0; k < 8; k++) begin
      push(0, 8'(8'h10 + k));
      expect_w(0, 8'(8'h10 + k));
    end
    refresh();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_valid_o && out_data_o == 8'h10) found = 1'b1;
    end
    chk("stall_first_word_seen", found, 1);
    step();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", out_data_o, 8'h11);
      chk("stall_ch", out_ch_o, 0);
      chk("stall_valid", out_valid_o, 1);
      chk("stall_rd_en", ch_rd_en_o, 0);
    end
    step();
    out_ready_i = 1'b1;
    wait_drain(40);

    // en_i low mid-burst on ch1; ch3 waits until re-enabled
    step();
    for (int k = 0; k < 6; k++) push(1, 8'(8'h20 + k));
    push(3, 8'h30); push(3, 8'h31);
    expect_w(1, 8'h20); expect_w(1, 8'h21); expect_w(1, 8'h22); expect_w(1, 8'h23);
    expect_w(3, 8'h30); expect_w(3, 8'h31);
    expect_w(1, 8'h24); expect_w(1, 8'h25);
    refresh();
    step();
    step();
    en_i = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_low_grant", grant_o, 0);
      chk("en_low_rd_en", ch_rd_en_o, 0);
    end
    chk("en_low_burst_words_left", exp_q.size(), 4);
    step();
    en_i = 1'b1;
    @(negedge clk);
    chk("en_rise_grant_same", grant_o, 0);
    @(negedge clk);
    chk("en_rise_grant_ch3", grant_o, 4'b1000);
    wait_drain(40);

    // Asynchronous reset mid-burst with a held output word
    step();
    out_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) push(2, 8'(8'h40 + k));
    push(0, 8'h50); push(0, 8'h51);
    refresh();
    repeat (3) @(negedge clk);
    chk("arst_pre_valid", out_valid_o, 1);
    chk("arst_pre_grant", grant_o, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_grant", grant_o, 0);
    chk("arst_rd_en", ch_rd_en_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_data", out_data_o, 0);
    expect_w(0, 8'h50); expect_w(0, 8'h51);
    expect_w(2, 8'h41); expect_w(2, 8'h42); expect_w(2, 8'h43);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("arst_restart_ch0", grant_o, 4'b0001);
    wait_drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
